// File: rtl/fft_frame_capture_ctrl.sv
// fft_frame_capture_ctrl
// Captures one frame of FFT samples into an external single-clock FIFO and
// then drains it to the MCU streamer through a valid/ready output register.
// The MCU holds rx_ready high for the whole transfer; dropping it aborts
// the transfer and flushes whatever is left in the FIFO.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no request, all enables low
// ARM   | request seen, waiting for a rising data_valid (frame start)
// FILL  | writing FFT samples until FRAME_LEN input samples have been seen
// DRAIN | reading FIFO into the output register, one sample per 2 cycles
// DONE  | frame delivered (or short frame), waiting for rx_ready to drop
// FLUSH | abort, reading FIFO until empty and discarding the data
module fft_frame_capture_ctrl #(
  parameter int DATA_W    = 14,
  parameter int FRAME_LEN = 1024,
  parameter int CNT_W     = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_ready,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_re,
  output logic              fifo_wr_en,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              tx_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_FILL  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4,
    S_FLUSH = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LEN  = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  state_t            state, state_nxt;
  logic              dv_q;
  logic              start;
  logic              pend;
  logic [CNT_W-1:0]  wr_cnt, rd_cnt;
  logic              wr_en, rd_en, done_evt;

  // Sample data goes straight from the FFT into the FIFO; not used here.
  logic unused_data;
  assign unused_data = ^data_re;

  assign start = data_valid & ~dv_q;

  // Next-state and FIFO enables; abort (rx_ready low) always wins.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    done_evt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_ready) state_nxt = S_ARM;
      end
      S_ARM: begin
        if (!rx_ready) begin
          state_nxt = S_IDLE;
        end else if (start) begin
          state_nxt = S_FILL;
          wr_en     = 1'b1;
        end
      end
      S_FILL: begin
        if (!rx_ready) begin
          state_nxt = S_FLUSH;
        end else begin
          wr_en = data_valid & ~fifo_full;
          if (data_valid && wr_cnt == LAST) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!rx_ready) begin
          state_nxt = S_FLUSH;
        end else begin
          rd_en = ~fifo_empty & ~pend & (rd_cnt < LEN) & (~out_valid | out_ready);
          if (rd_cnt == LEN && out_valid && out_ready) begin
            state_nxt = S_DONE;
            done_evt  = 1'b1;
          end else if (fifo_empty && !pend && rd_cnt < LEN && (!out_valid || out_ready)) begin
            // Short frame after an overflow: finish once the last held sample is taken.
            state_nxt = S_DONE;
            done_evt  = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (!rx_ready) state_nxt = S_IDLE;
      end
      S_FLUSH: begin
        rd_en = ~fifo_empty;
        if (fifo_empty && !pend) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Enables are held low during reset so a mid-operation reset is clean at once.
  assign fifo_wr_en = wr_en & ~rst;
  assign fifo_rd_en = rd_en & ~rst;

  // State register and data_valid history for frame-start detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      dv_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      dv_q  <= data_valid;
    end
  end

  // Counters, overflow flag, output register and registered status.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      pend       <= 1'b0;
      overflow   <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      tx_ready   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (state == S_IDLE && state_nxt == S_ARM) begin
        wr_cnt   <= '0;
        rd_cnt   <= '0;
        overflow <= 1'b0;
      end else if (state == S_ARM && state_nxt == S_FILL) begin
        wr_cnt <= CNT_W'(1);
      end else if (state == S_FILL && data_valid) begin
        // Dropped samples still count so the frame spans FRAME_LEN input samples.
        wr_cnt <= wr_cnt + 1'b1;
        if (fifo_full) overflow <= 1'b1;
      end

      pend <= rd_en;

      if (state == S_DRAIN && rx_ready) begin
        if (pend) begin
          out_data  <= fifo_dout;
          out_valid <= 1'b1;
          rd_cnt    <= rd_cnt + 1'b1;
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
      end else begin
        out_valid <= 1'b0;
      end

      tx_ready   <= (state_nxt == S_ARM);
      busy       <= (state_nxt != S_IDLE);
      frame_done <= done_evt;
    end
  end

endmodule

// File: tb/tb_fft_frame_capture_ctrl.sv
// Directed bench for fft_frame_capture_ctrl with a small behavioural FIFO.
module tb_fft_frame_capture_ctrl;

  localparam int DATA_W    = 14;
  localparam int FRAME_LEN = 8;
  localparam int CNT_W     = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_ready = 1'b0;
  logic              data_valid = 1'b0;
  logic [DATA_W-1:0] data_re = '0;
  logic              fifo_wr_en, fifo_rd_en;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              tx_ready, busy, frame_done, overflow;

  fft_frame_capture_ctrl #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .rx_ready(rx_ready), .data_valid(data_valid), .data_re(data_re),
    .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .tx_ready(tx_ready), .busy(busy),
    .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: depth 16, 1-cycle read latency, reset tied to rst.
  logic [DATA_W-1:0] mem [16];
  logic [3:0]        wp, rp;
  logic [4:0]        fcnt;
  logic              force_full = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      wp <= '0; rp <= '0; fcnt <= '0; fifo_dout <= '0;
    end else begin
      if (fifo_wr_en) begin mem[wp] <= data_re; wp <= wp + 4'd1; end
      if (fifo_rd_en) begin fifo_dout <= mem[rp]; rp <= rp + 4'd1; end
      if (fifo_wr_en && !fifo_rd_en) fcnt <= fcnt + 5'd1;
      else if (!fifo_wr_en && fifo_rd_en) fcnt <= fcnt - 5'd1;
    end
  end
  assign fifo_empty = (fcnt == 5'd0);
  assign fifo_full  = (fcnt == 5'd16) || force_full;

  // Observation at the falling edge.
  int                wr_log[$];
  int                out_log[$];
  int                done_cnt = 0;
  int                both_cnt = 0;
  int                stab_err = 0;
  logic              hold_prev = 1'b0;
  logic [DATA_W-1:0] hold_data = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_wr_en) wr_log.push_back(int'(data_re));
      if (out_valid && out_ready) out_log.push_back(int'(out_data));
      if (frame_done) done_cnt++;
      if (fifo_wr_en && fifo_rd_en) both_cnt++;
      if (hold_prev && out_data != hold_data) stab_err++;
      hold_prev = out_valid && !out_ready;
      hold_data = out_data;
    end else begin
      hold_prev = 1'b0;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  logic       bp_mode = 1'b0;
  logic [3:0] bp_pat  = 4'b1001;
  int         bp_idx  = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
    if (bp_mode) begin
      out_ready = bp_pat[bp_idx];
      bp_idx = (bp_idx + 1) % 4;
    end else begin
      out_ready = 1'b1;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic send(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      data_valid = 1'b1;
      data_re    = DATA_W'(first + i);
      cyc();
    end
    data_valid = 1'b0;
  endtask

  // sel 0 compares the FIFO write log, sel 1 the delivered-sample log.
  task automatic chk_stream(input string tag, input int sel, input int base, input int exp_q[$]);
    int got_n;
    got_n = (sel == 0) ? wr_log.size() - base : out_log.size() - base;
    chk({tag, "_count"}, 32'(got_n), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_n; i++)
      chk(tag, 32'((sel == 0) ? wr_log[base + i] : out_log[base + i]), 32'(exp_q[i]));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_tx_ready"},   32'(tx_ready),   32'd0);
    chk({tag, "_busy"},       32'(busy),       32'd0);
    chk({tag, "_out_valid"},  32'(out_valid),  32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_overflow"},   32'(overflow),   32'd0);
    chk({tag, "_wr_en"},      32'(fifo_wr_en), 32'd0);
    chk({tag, "_rd_en"},      32'(fifo_rd_en), 32'd0);
  endtask

  int exp_q[$];
  int wb, ob, db;

  initial begin
    // Reset
    rst = 1'b1;
    idle_cycles(2);
    chk_outputs_zero("reset");
    rst = 1'b0;
    cyc();

    // Nominal frame, out_ready tied high
    wb = wr_log.size(); ob = out_log.size(); db = done_cnt;
    rx_ready = 1'b1;
    cyc();
    chk("nom_tx_ready", 32'(tx_ready), 32'd1);
    chk("nom_busy", 32'(busy), 32'd1);
    send(1, 10);
    idle_cycles(30);
    exp_q = {1, 2, 3, 4, 5, 6, 7, 8};
    chk_stream("nom_wr", 0, wb, exp_q);
    chk_stream("nom_out", 1, ob, exp_q);
    chk("nom_done_pulses", 32'(done_cnt - db), 32'd1);
    chk("nom_busy_done", 32'(busy), 32'd1);
    chk("nom_tx_ready_done", 32'(tx_ready), 32'd0);
    idle_cycles(5);
    chk("nom_no_retrigger", 32'(done_cnt - db), 32'd1);
    rx_ready = 1'b0;
    cyc();
    chk("nom_busy_idle", 32'(busy), 32'd0);
    chk("nom_fifo_empty", 32'(fcnt), 32'd0);
    cyc();

    // Arm while a frame is already in progress
    wb = wr_log.size(); ob = out_log.size(); db = done_cnt;
    send(100, 2);
    data_valid = 1'b1;
    rx_ready   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_re = DATA_W'(110 + i);
      cyc();
    end
    chk("mid_no_writes", 32'(wr_log.size() - wb), 32'd0);
    chk("mid_tx_ready", 32'(tx_ready), 32'd1);
    data_valid = 1'b0;
    cyc();
    send(201, 10);
    idle_cycles(30);
    exp_q = {201, 202, 203, 204, 205, 206, 207, 208};
    chk_stream("mid_wr", 0, wb, exp_q);
    chk_stream("mid_out", 1, ob, exp_q);
    chk("mid_done_pulses", 32'(done_cnt - db), 32'd1);
    rx_ready = 1'b0;
    idle_cycles(2);

    // Backpressure 1,0,0,1 on out_ready
    wb = wr_log.size(); ob = out_log.size(); db = done_cnt;
    bp_mode = 1'b1; bp_idx = 0;
    rx_ready = 1'b1;
    cyc();
    send(301, 10);
    idle_cycles(80);
    exp_q = {301, 302, 303, 304, 305, 306, 307, 308};
    chk_stream("bp_out", 1, ob, exp_q);
    chk("bp_done_pulses", 32'(done_cnt - db), 32'd1);
    chk("bp_stable_data", 32'(stab_err), 32'd0);
    bp_mode = 1'b0;
    rx_ready = 1'b0;
    idle_cycles(2);

    // Abort during DRAIN after 3 samples
    ob = out_log.size(); db = done_cnt;
    rx_ready = 1'b1;
    cyc();
    send(401, 8);
    for (int i = 0; i < 50; i++) begin
      if (out_log.size() - ob >= 3) break;
      cyc();
    end
    chk("abort_three_seen", 32'(out_log.size() - ob), 32'd3);
    rx_ready = 1'b0;
    cyc();
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy_flush", 32'(busy), 32'd1);
    idle_cycles(20);
    chk("abort_busy_idle", 32'(busy), 32'd0);
    chk("abort_fifo_empty", 32'(fcnt), 32'd0);
    chk("abort_no_done", 32'(done_cnt - db), 32'd0);
    chk("abort_out_count", 32'(out_log.size() - ob), 32'd3);

    // Overflow: full forced for two FILL samples
    wb = wr_log.size(); ob = out_log.size(); db = done_cnt;
    rx_ready = 1'b1;
    cyc();
    for (int i = 0; i < 10; i++) begin
      data_valid = 1'b1;
      data_re    = DATA_W'(501 + i);
      force_full = (i == 2 || i == 3);
      cyc();
    end
    data_valid = 1'b0;
    force_full = 1'b0;
    idle_cycles(30);
    exp_q = {501, 502, 505, 506, 507, 508};
    chk_stream("ovf_wr", 0, wb, exp_q);
    chk_stream("ovf_out", 1, ob, exp_q);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_done_pulses", 32'(done_cnt - db), 32'd1);
    rx_ready = 1'b0;
    idle_cycles(2);
    chk("ovf_sticky_idle", 32'(overflow), 32'd1);
    rx_ready = 1'b1;
    cyc();
    chk("ovf_cleared_on_arm", 32'(overflow), 32'd0);

    // Reset during FILL after 4 writes, then a full frame
    wb = wr_log.size();
    send(601, 4);
    chk("rst_fill_writes", 32'(wr_log.size() - wb), 32'd4);
    rst = 1'b1;
    data_valid = 1'b1;
    data_re = DATA_W'(605);
    cyc();
    chk_outputs_zero("rst_fill");
    rst = 1'b0;
    data_valid = 1'b0;
    wb = wr_log.size(); ob = out_log.size(); db = done_cnt;
    cyc();
    chk("rst_rearm_tx_ready", 32'(tx_ready), 32'd1);
    send(701, 10);
    idle_cycles(30);
    exp_q = {701, 702, 703, 704, 705, 706, 707, 708};
    chk_stream("rst_wr", 0, wb, exp_q);
    chk_stream("rst_out", 1, ob, exp_q);
    chk("rst_done_pulses", 32'(done_cnt - db), 32'd1);
    rx_ready = 1'b0;
    idle_cycles(2);

    chk("never_wr_and_rd", 32'(both_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
